// File: rtl/aes_pkg.sv
// AES-128 shared definitions: FSM encoding, block/round constants, GF(2^8) helpers and the
// SubBytes / ShiftRows / MixColumns stage functions used by the round datapath.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W    = 128;
    localparam int unsigned NUM_ROUNDS_128 = 10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRound = 2'd1,
        StLast  = 2'd2,
        StDone  = 2'd3
    } aes_state_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mult3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] sub_bytes(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    // Byte b = row + 4*col lives at bits [8*(15-b) +: 8]; row r rotates left by r.
    function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] r;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[8*(15-(row+4*col)) +: 8] = s[8*(15-(row+4*((col+row)%4))) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] mix_columns(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] r;
        logic [7:0]             a0, a1, a2, a3;
        r = '0;
        for (int col = 0; col < 4; col++) begin
            a0 = s[8*(15-4*col) +: 8];
            a1 = s[8*(14-4*col) +: 8];
            a2 = s[8*(13-4*col) +: 8];
            a3 = s[8*(12-4*col) +: 8];
            r[8*(15-4*col) +: 8] = xtime(a0) ^ mult3(a1) ^ a2 ^ a3;
            r[8*(14-4*col) +: 8] = a0 ^ xtime(a1) ^ mult3(a2) ^ a3;
            r[8*(13-4*col) +: 8] = a0 ^ a1 ^ xtime(a2) ^ mult3(a3);
            r[8*(12-4*col) +: 8] = mult3(a0) ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-level valid/ready handshake plus the round-key request/response bus of the sequencer.
interface aes_round_sequencer_if #(
    parameter int unsigned IDX_W = 4
);
    logic                              InValid;
    logic                              InReady;
    logic [aes_pkg::AES_BLOCK_W-1:0]   InBlock;
    logic [IDX_W-1:0]                  RoundIdx;
    logic [aes_pkg::AES_BLOCK_W-1:0]   RoundKey;
    logic                              OutValid;
    logic                              OutReady;
    logic [aes_pkg::AES_BLOCK_W-1:0]   OutBlock;
    logic                              Busy;

    // Environment side: block producer/consumer and key schedule.
    modport master (
        output InValid, InBlock, RoundKey, OutReady,
        input  InReady, RoundIdx, OutValid, OutBlock, Busy
    );

    modport slave (
        input  InValid, InBlock, RoundKey, OutReady,
        output InReady, RoundIdx, OutValid, OutBlock, Busy
    );
endinterface

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey;
// i_last bypasses MixColumns for the final round.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] i_state,
    input  logic [AES_BLOCK_W-1:0] i_key,
    input  logic                   i_last,
    output logic [AES_BLOCK_W-1:0] o_state
);
    logic [AES_BLOCK_W-1:0] w_sub;
    logic [AES_BLOCK_W-1:0] w_shift;
    logic [AES_BLOCK_W-1:0] w_mix;

    assign w_sub   = sub_bytes(i_state);
    assign w_shift = shift_rows(w_sub);
    assign w_mix   = i_last ? w_shift : mix_columns(w_shift);
    assign o_state = w_mix ^ i_key;
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: FSM, round counter and state register around one
// shared round datapath. Define AES_ABORT_EN to add the Abort input that cancels a block in flight.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_128,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef AES_ABORT_EN
    input  logic                Abort,
`endif
    aes_round_sequencer_if.slave bus
);
    aes_state_e             r_state;
    aes_state_e             w_state_nxt;
    logic [IDX_W-1:0]       r_ctr;
    logic [IDX_W-1:0]       w_ctr_nxt;
    logic [AES_BLOCK_W-1:0] r_data;
    logic [AES_BLOCK_W-1:0] w_data_nxt;
    logic [AES_BLOCK_W-1:0] w_round_out;
    logic                   w_last;
    logic                   w_abort;

`ifdef AES_ABORT_EN
    assign w_abort = Abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last = (r_state == StLast);

    aes_round_comb u_round (
        .i_state (r_data),
        .i_key   (bus.RoundKey),
        .i_last  (w_last),
        .o_state (w_round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ctr   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctr   <= w_ctr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ctr_nxt    = r_ctr;
        w_data_nxt   = r_data;
        bus.InReady  = 1'b0;
        bus.OutValid = 1'b0;
        bus.OutBlock = '0;
        bus.Busy     = 1'b0;
        // Counter is zero in IDLE, so this also yields key index 0 for the initial whitening.
        bus.RoundIdx = r_ctr;

        unique case (r_state)
            StIdle: begin
                bus.InReady = 1'b1;
                if (bus.InValid) begin
                    w_data_nxt  = bus.InBlock ^ bus.RoundKey;
                    w_ctr_nxt   = IDX_W'(1);
                    w_state_nxt = StRound;
                end
            end
            StRound: begin
                bus.Busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = StIdle;
                    w_ctr_nxt   = '0;
                    w_data_nxt  = '0;
                end else begin
                    w_data_nxt = w_round_out;
                    w_ctr_nxt  = r_ctr + 1'b1;
                    if (r_ctr == IDX_W'(NUM_ROUNDS - 1)) begin
                        w_state_nxt = StLast;
                    end
                end
            end
            StLast: begin
                bus.Busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = StIdle;
                    w_ctr_nxt   = '0;
                    w_data_nxt  = '0;
                end else begin
                    w_data_nxt  = w_round_out;
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                bus.OutValid = 1'b1;
                bus.OutBlock = r_data;
                if (bus.OutReady) begin
                    w_state_nxt = StIdle;
                    w_ctr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: FIPS-197 vectors and random blocks against a byte-level AES model
// with its own computed S-box and key schedule. Define AES_ABORT_EN to cover the abort path.
module tb_aes_round_sequencer;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]   sbox_t [256];
    logic [127:0] rk [16];
`ifdef AES_ABORT_EN
    logic abort;
`endif

    aes_round_sequencer_if #(.IDX_W(4)) bus ();

    always #5 clk = ~clk;

    // Key schedule answers combinationally for whatever index the sequencer requests.
    assign bus.RoundKey = rk[bus.RoundIdx];

    aes_round_sequencer #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef AES_ABORT_EN
        .Abort (abort),
`endif
        .bus   (bus)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then the affine map.
    task automatic init_sbox();
        logic [7:0] inv, b, s;
        for (int v = 0; v < 256; v++) begin
            b   = 8'(v);
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, b);
            end
            s = inv; b = inv;
            for (int k = 0; k < 4; k++) begin
                b = {b[6:0], b[7]};
                s = s ^ b;
            end
            sbox_t[v] = s ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= 10) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk[r] = '0;
        end
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] blk;
        blk = pt ^ rk[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] = sbox_t[blk[127-8*(r+4*c) -: 8]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = s[r][(c+r)%4];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = (rnd == 10) ? t[r][c] :
                              gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^
                              t[(r+2)%4][c] ^ t[(r+3)%4][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    blk[127-8*(r+4*c) -: 8] = s[r][c] ^ rk[rnd][127-8*(r+4*c) -: 8];
        end
        return blk;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer one block from IDLE, follow it cycle by cycle, stall the consumer, then drain it.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp_ct, input string tag,
                             input int unsigned stall, input bit offer_in_stall);
        logic [127:0] hold_blk;
        load_key(key);
        bus.InBlock  = pt;
        bus.InValid  = 1'b1;
        bus.OutReady = 1'b0;
        vectors++;
        if (bus.InReady !== 1'b1 || bus.RoundIdx !== 4'd0) begin
            miscompares++;
            $display("FAIL %s idle: InReady=%b RoundIdx=%0d, want 1 0", tag, bus.InReady,
                     bus.RoundIdx);
        end
        step();
        bus.InValid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            vectors++;
            if ({bus.Busy, bus.OutValid, bus.InReady, bus.RoundIdx} !== {3'b100, 4'(c)}) begin
                miscompares++;
                $display("FAIL %s cycle %0d: Busy/OutValid/InReady/RoundIdx=%b/%b/%b/%0d, want 1/0/0/%0d",
                         tag, c, bus.Busy, bus.OutValid, bus.InReady, bus.RoundIdx, c);
            end
            step();
        end
        vectors++;
        if (bus.OutValid !== 1'b1 || bus.Busy !== 1'b0 || bus.OutBlock !== exp_ct) begin
            miscompares++;
            $display("FAIL %s result cycle 11: OutValid=%b Busy=%b OutBlock=%h, want 1 0 %h",
                     tag, bus.OutValid, bus.Busy, bus.OutBlock, exp_ct);
        end
        if (offer_in_stall) begin
            bus.InBlock = rand128();
            bus.InValid = 1'b1;
        end
        for (int s = 0; s < int'(stall); s++) begin
            step();
            vectors++;
            if (bus.OutValid !== 1'b1 || bus.InReady !== 1'b0 || bus.OutBlock !== exp_ct) begin
                miscompares++;
                $display("FAIL %s stall %0d: OutValid=%b InReady=%b OutBlock=%h, want 1 0 %h",
                         tag, s, bus.OutValid, bus.InReady, bus.OutBlock, exp_ct);
            end
        end
        hold_blk = bus.OutBlock;
        bus.OutReady = 1'b1;
        step();
        bus.OutReady = 1'b0;
        bus.InValid  = 1'b0;
        vectors++;
        if ({bus.OutValid, bus.InReady, bus.Busy} !== 3'b010 || hold_blk !== exp_ct) begin
            miscompares++;
            $display("FAIL %s drain: OutValid/InReady/Busy=%b/%b/%b held=%h, want 0/1/0 %h",
                     tag, bus.OutValid, bus.InReady, bus.Busy, hold_blk, exp_ct);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({bus.InReady, bus.OutValid, bus.Busy} !== 3'b100 || bus.RoundIdx !== 4'd0 ||
            bus.OutBlock !== 128'h0) begin
            miscompares++;
            $display("FAIL %s: InReady/OutValid/Busy=%b/%b/%b RoundIdx=%0d OutBlock=%h, want 1/0/0 0 0",
                     tag, bus.InReady, bus.OutValid, bus.Busy, bus.RoundIdx, bus.OutBlock);
        end
    endtask

    task automatic check_quiet(input string tag, input int unsigned cycles);
        int unsigned seen;
        seen = 0;
        for (int i = 0; i < int'(cycles); i++) begin
            if (bus.OutValid !== 1'b0) seen++;
            step();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL %s: OutValid high in %0d cycles, want 0", tag, seen);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("reset_async");
        step();
        step();
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        step();
        check_reset_outputs("reset_released");
    endtask

    task automatic test_fips();
        run_block(C1_KEY, C1_PT, C1_CT, "fips_c1", 0, 1'b0);
        run_block(B_KEY, B_PT, B_CT, "fips_b", 2, 1'b0);
    endtask

    task automatic test_random();
        logic [127:0] key, pt;
        for (int n = 0; n < 6; n++) begin
            key = rand128();
            pt  = rand128();
            load_key(key);
            run_block(key, pt, model_encrypt(pt), "random", $urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt;
        pt = rand128();
        load_key(B_KEY);
        run_block(B_KEY, pt, model_encrypt(pt), "backpressure", 20, 1'b1);
        step();
        vectors++;
        if (bus.InReady !== 1'b1 || bus.Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_no_accept: InReady=%b Busy=%b, want 1 0", bus.InReady,
                     bus.Busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q [$];
        logic [127:0] pt, exp;
        int           n_acc, n_out, last_acc;
        bit           acc;
        load_key(C1_KEY);
        n_acc = 0; n_out = 0; last_acc = 0;
        pt = rand128();
        bus.InBlock  = pt;
        bus.InValid  = 1'b1;
        bus.OutReady = 1'b1;
        for (int cyc = 0; cyc < 80 && n_out < 3; cyc++) begin
            acc = bus.InValid && bus.InReady;
            if (bus.OutValid === 1'b1) begin
                vectors++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                if (bus.OutBlock !== exp) begin
                    miscompares++;
                    $display("FAIL b2b out %0d: OutBlock=%h, want %h", n_out, bus.OutBlock, exp);
                end
                n_out++;
            end
            if (acc) begin
                if (n_acc > 0) begin
                    vectors++;
                    if (cyc - last_acc != 12) begin
                        miscompares++;
                        $display("FAIL b2b spacing: %0d cycles, want 12", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                exp_q.push_back(model_encrypt(pt));
                n_acc++;
            end
            step();
            if (acc) begin
                pt = rand128();
                bus.InBlock = pt;
                if (n_acc == 3) bus.InValid = 1'b0;
            end
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b0;
        vectors++;
        if (n_out != 3 || n_acc != 3) begin
            miscompares++;
            $display("FAIL b2b count: accepted %0d emitted %0d, want 3 3", n_acc, n_out);
        end
        step();
    endtask

    task automatic test_reset_mid();
        load_key(C1_KEY);
        bus.InBlock = C1_PT;
        bus.InValid = 1'b1;
        step();
        bus.InValid = 1'b0;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_async");
        step();
        step();
        rst_n = 1'b1;
        check_quiet("reset_mid_no_output", 15);
        run_block(C1_KEY, C1_PT, C1_CT, "after_reset_mid", 1, 1'b0);
    endtask

`ifdef AES_ABORT_EN
    task automatic test_abort();
        load_key(C1_KEY);
        bus.InBlock = rand128();
        bus.InValid = 1'b1;
        step();
        bus.InValid = 1'b0;
        repeat (3) step();
        vectors++;
        if (bus.RoundIdx !== 4'd4 || bus.Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_setup: RoundIdx=%0d Busy=%b, want 4 1", bus.RoundIdx, bus.Busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_reset_outputs("abort_to_idle");
        check_quiet("abort_no_output", 15);
        run_block(C1_KEY, C1_PT, C1_CT, "after_abort", 0, 1'b0);
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        bus.InValid  = 1'b0;
        bus.InBlock  = '0;
        bus.OutReady = 1'b0;
`ifdef AES_ABORT_EN
        abort        = 1'b0;
`endif
        init_sbox();
        load_key(C1_KEY);
        test_reset();
        test_fips();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
